// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a valid/ready instruction-memory port.
// It takes a start from the control FSM, issues one request at pc_cur, and waits for
// the response. It then loads the instruction register and pulses ir_write.
// It also handles flush (redirect) of an in-flight fetch and a response watchdog.
// Optional feature: define FETCH_CTRL_MISALIGN_CHECK_EN to reject a start whose
// pc_cur[1:0] is non-zero with a fault (code 2'b10). No request is made in that case.
module fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] pc_cur,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        ir_write,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic            req_valid_reg;
    logic [31:0]     req_addr_reg;
    logic [31:0]     instr_reg;
    logic            busy_reg;
    logic [1:0]      fault_code_reg;

    logic            cnt_hit;
    logic            start_ok;
    logic            misalign_fault;
    logic            timeout_fault;
    logic            rsp_take;
    logic [1:0]      fault_code_next;

    // The watchdog trips in the cycle whose increment would land on TIMEOUT_CYCLES,
    // so the fault marks the TIMEOUT_CYCLES-th cycle spent waiting.
    assign cnt_hit = ((CNT_W + 1)'(cnt_reg) + (CNT_W + 1)'(1)) == (CNT_W + 1)'(TIMEOUT_CYCLES);

    // flush beats start in IDLE, so nothing is latched when both are high
    assign start_ok = (state_reg == IDLE) && start && !flush;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    assign misalign_fault = start_ok && (pc_cur[1:0] != 2'b00);
`else
    assign misalign_fault = 1'b0;
`endif

    // Mealy outputs: derived only from the registered state plus the current inputs.
    // A response cycle never coincides with a timeout cycle.
    assign rsp_take      = (state_reg == WAIT) && imem_rsp_valid && !flush;
    assign timeout_fault = (state_reg == WAIT) && !imem_rsp_valid && !flush && cnt_hit;

    assign ir_write = rsp_take;
    assign fault    = misalign_fault | timeout_fault;

    // The new code is visible during the fault pulse itself, then held by the register.
    assign fault_code_next = timeout_fault  ? 2'b01 :
                             misalign_fault ? 2'b10 : fault_code_reg;
    assign fault_code      = fault_code_next;

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = req_addr_reg;
    assign instr          = instr_reg;
    assign busy           = busy_reg;

    // Fetch FSM with its registered outputs, watchdog counter and instruction register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_valid_reg  <= 1'b0;
            req_addr_reg   <= '0;
            instr_reg      <= '0;
            busy_reg       <= 1'b0;
            fault_code_reg <= 2'b00;
        end else begin
            if (fault) begin
                fault_code_reg <= fault_code_next;
            end
            if (rsp_take) begin
                instr_reg <= imem_rsp_data;
            end

            case (state_reg)
                IDLE: begin
                    if (start_ok && !misalign_fault) begin
                        req_addr_reg  <= pc_cur;
                        req_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= REQ;
                    end
                end

                REQ: begin
                    if (flush) begin
                        req_valid_reg <= 1'b0;
                        cnt_reg       <= '0;
                        if (imem_req_ready) begin
                            // accepted request still owes a response: drain it
                            state_reg <= DROP;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else if (imem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid) begin
                        // with flush the data is simply not written
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (flush || cnt_hit) begin
                        state_reg <= DROP;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                DROP: begin
                    // discard the owed response, or give up silently after the watchdog
                    if (imem_rsp_valid || cnt_hit) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl.
// Each transaction is planned as a timeline (cycle offsets of start, ready, flush,
// response) and its observable events are predicted from that plan arithmetically.
// A separate monitor pops and compares them as the DUT produces them.
module tb_fetch_ctrl;
    localparam int TO = 4;

    localparam int EV_REQ  = 0;
    localparam int EV_IRW  = 1;
    localparam int EV_FLT  = 2;
    localparam int EV_IDLE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_cur = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr;
    logic        ir_write;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    int          txn_id = 0;
    logic [31:0] exp_instr = '0;

    fetch_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .flush          (flush),
        .pc_cur         (pc_cur),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .ir_write       (ir_write),
        .busy           (busy),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    task automatic push_ev(input int kind, input int c, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Compare one observed DUT event against the oldest expectation
    task automatic observe(input int kind, input logic [31:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: actual kind=%0d cyc=%0d data=%h, required none", kind, cyc, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.data == data) passed++;
            else $display("FAIL event: actual kind=%0d cyc=%0d data=%h, required kind=%0d cyc=%0d data=%h",
                          kind, cyc, data, e.kind, e.cyc, e.data);
        end
    endtask

    // Monitor: samples mid-cycle, reports events and checks request stability
    initial begin
        logic        busy_prev = 1'b0;
        logic        rv_prev   = 1'b0;
        logic        hs_prev   = 1'b0;
        logic        fl_prev   = 1'b0;
        logic [31:0] addr_prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                rv_prev   = 1'b0;
                hs_prev   = 1'b0;
                fl_prev   = 1'b0;
            end else begin
                if (rv_prev && !hs_prev && !fl_prev)
                    chk(imem_req_valid && imem_req_addr == addr_prev, "req_stable",
                        imem_req_addr, addr_prev);
                if (imem_req_valid && imem_req_ready) observe(EV_REQ, imem_req_addr);
                if (ir_write || fault) chk(!(ir_write && fault), "irw_fault_exclusive", 32'(fault), 32'(0));
                if (ir_write) observe(EV_IRW, 32'h0);
                if (fault) observe(EV_FLT, {30'h0, fault_code});
                if (busy_prev && !busy) observe(EV_IDLE, instr);
                busy_prev = busy;
                rv_prev   = imem_req_valid;
                hs_prev   = imem_req_valid && imem_req_ready;
                fl_prev   = flush;
                addr_prev = imem_req_addr;
            end
        end
    end

    task automatic drive(input logic s, input logic fl, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic [31:0] pc);
        start          = s;
        flush          = fl;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        pc_cur         = pc;
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain fetch (d>=TO means no response -> timeout, then drain)
    // mode 1: flush in REQ at REQ cycle k while ready is low
    // mode 2: flush in the cycle the request is accepted
    // mode 3: flush at WAIT cycle f with no response, then drain
    // mode 4: flush at WAIT cycle f together with the response
    // g: DROP cycle of the late response, or -1 for none
    task automatic run_txn(input logic [31:0] addr, input int mode, input int r, input int k,
                           input int d, input int f, input int g, input logic [31:0] rdata);
        int T, rdy_o, flush_o, rsp_o, drsp_o, flt_o, idle_o, dstart, req_last;
        logic s, fl, rdy, rv;
        logic [31:0] rd;
        T = cyc;
        rdy_o = -1; flush_o = -1; rsp_o = -1; drsp_o = -1; flt_o = -1; idle_o = 1; dstart = -1;
        txn_id++;
        $display("txn %0d addr=%h mode=%0d r=%0d k=%0d d=%0d f=%0d g=%0d data=%h",
                 txn_id, addr, mode, r, k, d, f, g, rdata);
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin
            push_ev(EV_FLT, T, 32'h2);
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom, addr);
            return;
        end
`endif
        case (mode)
            0: begin
                rdy_o = 1 + r;
                if (d < TO) begin
                    rsp_o  = 2 + r + d;
                    idle_o = rsp_o + 1;
                end else begin
                    flt_o  = 1 + r + TO;
                    dstart = flt_o + 1;
                end
            end
            1: begin
                flush_o = 1 + k;
                idle_o  = flush_o + 1;
            end
            2: begin
                rdy_o   = 1 + r;
                flush_o = rdy_o;
                dstart  = rdy_o + 1;
            end
            3: begin
                rdy_o   = 1 + r;
                flush_o = 2 + r + f;
                dstart  = flush_o + 1;
            end
            default: begin
                rdy_o   = 1 + r;
                flush_o = 2 + r + f;
                rsp_o   = flush_o;
                idle_o  = rsp_o + 1;
            end
        endcase
        if (dstart >= 0) begin
            if (g >= 0) begin
                drsp_o = dstart + g;
                idle_o = dstart + g + 1;
            end else begin
                idle_o = dstart + TO;
            end
        end
        req_last = (rdy_o >= 0) ? rdy_o : flush_o;

        if (rdy_o >= 0) push_ev(EV_REQ, T + rdy_o, addr);
        if (mode == 0 && rsp_o >= 0) begin
            push_ev(EV_IRW, T + rsp_o, 32'h0);
            exp_instr = rdata;
        end
        if (flt_o >= 0) push_ev(EV_FLT, T + flt_o, 32'h1);
        push_ev(EV_IDLE, T + idle_o, exp_instr);

        for (int o = 0; o < idle_o; o++) begin
            s   = (o == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            fl  = (o == flush_o);
            if (o >= 1 && o <= req_last) rdy = (o == rdy_o);
            else rdy = 1'($urandom_range(0, 1));
            if (o == rsp_o || o == drsp_o) rv = 1'b1;
            else if (o <= req_last) rv = 1'($urandom_range(0, 1));
            else rv = 1'b0;
            rd = (o == rsp_o || o == drsp_o) ? rdata : $urandom;
            drive(s, fl, rdy, rv, rd, (o == 0) ? addr : $urandom);
        end

        // idle gap: start only together with flush, stray responses are ignored
        for (int n = $urandom_range(0, 2); n > 0; n--) begin
            s  = 1'($urandom_range(0, 1));
            fl = s ? 1'b1 : 1'($urandom_range(0, 1));
            drive(s, fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    task automatic reset_in_wait();
        int T;
        T = cyc;
        txn_id++;
        $display("txn %0d reset asserted in WAIT", txn_id);
        push_ev(EV_REQ, T + 1, 32'h200);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        chk(imem_req_valid == 1'b0, "rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk(imem_req_addr == 32'h0, "rst_req_addr", imem_req_addr, 32'h0);
        chk(instr == 32'h0, "rst_instr", instr, 32'h0);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
        chk(fault_code == 2'b00, "rst_fault_code", 32'(fault_code), 32'h0);
        chk(ir_write == 1'b0 && fault == 1'b0, "rst_pulses", 32'({ir_write, fault}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instr = 32'h0;
        for (int n = 0; n < 2; n++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h1234_5678;
            #1;
            chk(ir_write == 1'b0, "late_rsp_no_irw", 32'(ir_write), 32'h0);
            @(posedge clk);
            #1;
        end
        imem_rsp_valid = 1'b0;
        chk(instr == 32'h0 && busy == 1'b0, "after_late_rsp", instr, 32'h0);
    endtask

    initial begin
        int mode, r, k, d, f, g;
        logic [31:0] addr;
        repeat (2) @(posedge clk);
        #1;
        chk(imem_req_valid == 1'b0, "reset_req_valid", 32'(imem_req_valid), 32'h0);
        chk(imem_req_addr == 32'h0, "reset_req_addr", imem_req_addr, 32'h0);
        chk(instr == 32'h0, "reset_instr", instr, 32'h0);
        chk(busy == 1'b0, "reset_busy", 32'(busy), 32'h0);
        chk(ir_write == 1'b0 && fault == 1'b0, "reset_pulses", 32'({ir_write, fault}), 32'h0);
        chk(fault_code == 2'b00, "reset_fault_code", 32'(fault_code), 32'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // directed: minimum latency, long REQ stall, flush in WAIT, timeout, misalign
        run_txn(32'h0000_0100, 0, 0, 0, 0, 0, -1, 32'h0050_0093);
        chk(imem_req_addr == 32'h100, "first_req_addr", imem_req_addr, 32'h100);
        run_txn(32'h0000_0104, 0, 5, 0, 1, 0, -1, 32'h1111_2222);
        run_txn(32'h0000_0108, 3, 0, 0, 0, 0, 2, 32'hDEAD_BEEF);
        run_txn(32'h0000_010C, 0, 1, 0, 2, 0, -1, 32'h3333_4444);
        run_txn(32'h0000_0110, 0, 0, 0, TO, 0, 1, 32'h5555_6666);
        run_txn(32'h0000_0114, 0, 0, 0, TO, 0, -1, 32'h7777_8888);
        run_txn(32'h0000_0102, 0, 0, 0, 0, 0, -1, 32'h9999_AAAA);
        run_txn(32'h0000_0118, 1, 3, 2, 0, 0, -1, 32'h0);
        run_txn(32'h0000_011C, 2, 1, 0, 0, 0, 0, 32'hBBBB_CCCC);
        run_txn(32'h0000_0120, 4, 0, 0, 0, TO - 1, -1, 32'hCCCC_DDDD);
        run_txn(32'h0000_0124, 3, 0, 0, 0, TO - 1, -1, 32'h0);
        reset_in_wait();
        run_txn(32'h0000_0200, 0, 0, 0, 0, 0, -1, 32'h0000_0013);

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 4);
            r    = $urandom_range(0, 3);
            if (mode == 1 && r == 0) r = 1;
            k    = (r > 0) ? $urandom_range(0, r - 1) : 0;
            d    = $urandom_range(0, TO + 1);
            f    = $urandom_range(0, TO - 1);
            g    = $urandom_range(0, TO);
            if (g == TO) g = -1;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_txn(addr, mode, r, k, d, f, g, $urandom);
        end

        for (int n = 0; n < 2 * TO + 4; n++) drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk(exp_q.size() == 0, "events_outstanding", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
